// File: rtl/key_pio_pkg.sv
// Shared constants and helpers for the key input PIO.
// Register offsets and debounce counter sizing.
package key_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One input bit: 2-flop synchroniser, stability counter and
// the accepted (debounced) level.
module key_debounce
  import key_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RST_VAL         = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Bring the raw pin into the clock domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has held for the full window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == TERM) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q <= RST_VAL;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/key_pio_reader.sv
// Avalon-MM input PIO for push-buttons/switches: debounced data,
// edge capture with write-1-to-clear, and a maskable level irq.
module key_pio_reader
  import key_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_FALLING    = 1
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] keys_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  localparam logic RST_LVL = (EDGE_FALLING != 0);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] pulse;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic             irq_q;
  logic             irq_d;
  logic [31:0]      rdata_q;
  logic [31:0]      rdata_d;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST_VAL        (RST_LVL)
    ) u_db (
      .clk_i   (clk_clk),
      .rst_i   (reset_reset),
      .raw_i   (keys_in[i]),
      .stable_o(stable[i])
    );
  end

  assign wdata        = avs_writedata[WIDTH-1:0];
  assign unused_wdata = ^avs_writedata;

  // Remember last cycle's debounced level for edge detection.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      prev_q <= {WIDTH{RST_LVL}};
    end else begin
      prev_q <= stable;
    end
  end

  // One-cycle pulse on the selected transition direction.
  always_comb begin
    pulse = '0;
    if (EDGE_FALLING != 0) begin
      pulse = prev_q & ~stable;
    end else begin
      pulse = ~prev_q & stable;
    end
  end

  // Register writes, edge capture (set beats clear) and read mux.
  always_comb begin
    mask_d  = mask_q;
    clr     = '0;
    rdata_d = rdata_q;
    if (avs_write && avs_address == ADDR_MASK) begin
      mask_d = wdata;
    end
    if (avs_write && avs_address == ADDR_EDGE) begin
      clr = wdata;
    end
    edge_d = (edge_q & ~clr) | pulse;
    irq_d  = |(edge_q & mask_q);
    if (avs_read) begin
      case (avs_address)
        ADDR_DATA: rdata_d = 32'(stable);
        ADDR_MASK: rdata_d = 32'(mask_q);
        ADDR_EDGE: rdata_d = 32'(edge_q);
        default:   rdata_d = 32'd0;
      endcase
    end
  end

  // Bus-visible state registers.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      mask_q  <= '0;
      edge_q  <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_key_pio_reader.sv
// Bench for key_pio_reader: window-based reference model checked
// every cycle, plus directed literal expectations.
module tb_key_pio_reader;

  localparam int W = 4;
  localparam int N = 8;

  logic        clk_clk       = 1'b0;
  logic        reset_reset   = 1'b1;
  logic [3:0]  keys_in       = 4'hF;
  logic [1:0]  avs_address   = 2'd0;
  logic        avs_read      = 1'b0;
  logic        avs_write     = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk_clk = ~clk_clk;

  key_pio_reader #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(N),
    .EDGE_FALLING   (1)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .keys_in      (keys_in),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: keys seen two cycles late; a bit flips once the
  // last N delayed samples all disagree with the accepted level.
  logic [3:0]  hq[$];
  logic [3:0]  m_stable = 4'hF;
  logic [3:0]  m_prev   = 4'hF;
  logic [3:0]  m_edge   = 4'h0;
  logic [3:0]  m_mask   = 4'h0;
  logic        m_irq    = 1'b0;
  logic [31:0] m_rdata  = 32'd0;

  task automatic model_reset();
    hq.delete();
    for (int i = 0; i < N + 2; i++) hq.push_back(4'hF);
    m_stable = 4'hF;
    m_prev   = 4'hF;
    m_edge   = 4'h0;
    m_mask   = 4'h0;
    m_irq    = 1'b0;
    m_rdata  = 32'd0;
  endtask

  task automatic model_step();
    logic [3:0] pulse;
    logic [3:0] clr;
    logic [3:0] nst;
    bit         dis;
    int         sz;
    pulse = m_prev & ~m_stable;
    if (avs_read) begin
      case (avs_address)
        2'd0:    m_rdata = {28'd0, m_stable};
        2'd1:    m_rdata = {28'd0, m_mask};
        2'd3:    m_rdata = {28'd0, m_edge};
        default: m_rdata = 32'd0;
      endcase
    end
    clr = (avs_write && avs_address == 2'd3) ? avs_writedata[3:0] : 4'h0;
    m_irq  = |(m_edge & m_mask);
    m_edge = (m_edge & ~clr) | pulse;
    if (avs_write && avs_address == 2'd1) m_mask = avs_writedata[3:0];
    hq.push_back(keys_in);
    if (hq.size() > N + 2) void'(hq.pop_front());
    sz  = hq.size();
    nst = m_stable;
    for (int b = 0; b < W; b++) begin
      dis = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (hq[sz-3-k][b] == m_stable[b]) dis = 1'b0;
      end
      if (dis) nst[b] = ~m_stable[b];
    end
    m_prev   = m_stable;
    m_stable = nst;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_clk or posedge reset_reset);
      if (reset_reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk_clk);
      check("irq_model", 32'(irq), 32'(m_irq));
      check("rdata_model", avs_readdata, m_rdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk_clk);
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk_clk);
    d        = avs_readdata;
    avs_read = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int first_d;
    int first_irq;
    int irq_hi;

    tick(3);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", avs_readdata, 32'd0);
    reset_reset = 1'b0;

    irq_hi = 0;
    repeat (100) begin
      @(negedge clk_clk);
      if (irq) irq_hi++;
    end
    check("idle_irq_cycles", 32'(irq_hi), 32'd0);
    rd(2'd0, d); check("idle_data", d, 32'h0000000F);
    rd(2'd3, d); check("idle_edge", d, 32'd0);

    keys_in = 4'hD; tick(5);
    keys_in = 4'hF; tick(20);
    rd(2'd0, d); check("glitch_data", d, 32'h0000000F);
    rd(2'd3, d); check("glitch_edge", d, 32'd0);

    wr(2'd1, 32'h2);
    avs_address = 2'd0;
    avs_read    = 1'b1;
    keys_in     = 4'hD;
    first_d     = 0;
    first_irq   = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_clk);
      if (first_d == 0 && avs_readdata[3:0] == 4'hD) first_d = k;
      if (first_irq == 0 && irq) first_irq = k;
    end
    avs_read = 1'b0;
    check("data_latency", 32'(first_d), 32'd11);
    check("irq_latency", 32'(first_irq), 32'd12);
    rd(2'd3, d); check("press_edge", d, 32'h2);

    wr(2'd3, 32'h2);
    check("irq_hold_after_clr", 32'(irq), 32'd1);
    tick(1);
    check("irq_clr", 32'(irq), 32'd0);
    rd(2'd3, d); check("edge_cleared", d, 32'd0);

    keys_in = 4'hF; tick(20);
    keys_in = 4'hD; tick(10);
    wr(2'd3, 32'h2);
    rd(2'd3, d); check("set_wins", d, 32'h2);
    check("set_wins_irq", 32'(irq), 32'd1);

    wr(2'd1, 32'h0);
    wr(2'd3, 32'hF);
    keys_in = 4'hF; tick(20);
    keys_in = 4'hE; tick(20);
    rd(2'd3, d); check("mask0_edge", d, 32'h1);
    check("mask0_irq", 32'(irq), 32'd0);
    wr(2'd1, 32'h1);
    check("mask_irq_delay", 32'(irq), 32'd0);
    tick(1);
    check("mask_irq_on", 32'(irq), 32'd1);
    wr(2'd0, 32'hFFFFFFFF);
    rd(2'd0, d); check("data_ro", d, 32'h0000000E);
    rd(2'd1, d); check("mask_rb", d, 32'h1);

    keys_in = 4'hF; tick(7);
    #2 reset_reset = 1'b1;
    #1;
    check("async_irq", 32'(irq), 32'd0);
    check("async_rdata", avs_readdata, 32'd0);
    tick(2);
    reset_reset = 1'b0;
    tick(30);
    rd(2'd3, d); check("post_rst_edge", d, 32'd0);
    check("post_rst_irq", 32'(irq), 32'd0);
    rd(2'd0, d); check("post_rst_data", d, 32'h0000000F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
